// File: rtl/spike_frame_router.sv
// spike_frame_router: decodes spike packets into per-core axon vectors held in a double-buffered frame store.
// Optional duplicate-hit counter is compiled in when SPIKE_FRAME_ROUTER_DUP_CNT_EN is defined.
`default_nettype none

module spike_frame_router #(
    parameter int NUM_CORES = 5,
    parameter int NUM_AXONS = 256,
    parameter int CNT_W     = 16
) (
    input  logic                             wb_clk_i,
    input  logic                             wb_rst_i,
    input  logic                             pkt_valid_i,
    output logic                             pkt_ready_o,
    input  logic [31:0]                      pkt_data_i,
    input  logic                             frame_end_i,
    output logic                             frame_valid_o,
    input  logic                             frame_ready_i,
    input  logic [$clog2(NUM_CORES)-1:0]     rd_core_i,
    input  logic [$clog2(NUM_AXONS/32)-1:0]  rd_word_i,
    output logic [31:0]                      rd_data_o,
    output logic [CNT_W-1:0]                 fill_cnt_o,
    output logic [CNT_W-1:0]                 drop_cnt_o,
    output logic [CNT_W-1:0]                 dup_cnt_o
);

    localparam int CORE_W = $clog2(NUM_CORES);
    localparam int AX_W   = $clog2(NUM_AXONS);
    localparam logic [AX_W-1:0] TOP_BASE = AX_W'(NUM_AXONS - 32);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_READY = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t                                       r_state;
    logic                                         r_fsel;
    logic [1:0][NUM_CORES-1:0][NUM_AXONS-1:0]     r_bank;
    logic                                         r_pkt_ready;
    logic                                         r_frame_valid;
    logic [31:0]                                  r_rd_data;
    logic [CNT_W-1:0]                             r_fill_cnt;
    logic [CNT_W-1:0]                             r_drop_cnt;

    state_t                 w_state_nxt;
    logic                   w_swap;
    logic [8:0]             w_dx;
    logic [CORE_W-1:0]      w_core;
    logic [AX_W-1:0]        w_axon;
    logic                   w_accept;
    logic                   w_in_range;
    logic                   w_wr_en;
    logic                   w_drop;
    logic                   w_rsel_nxt;
    logic [NUM_AXONS-1:0]   w_row;
    logic [AX_W-1:0]        w_base;
    logic [31:0]            w_rd_word;
    logic                   w_unused;

    assign w_dx       = pkt_data_i[29:21];
    assign w_core     = w_dx[CORE_W-1:0];
    assign w_axon     = pkt_data_i[4 +: AX_W];
    assign w_accept   = pkt_valid_i & r_pkt_ready;
    assign w_in_range = (w_dx < 9'(NUM_CORES));
    assign w_wr_en    = w_accept & w_in_range;
    assign w_drop     = w_accept & ~w_in_range;
    assign w_unused   = ^pkt_data_i;

    always_comb begin
        w_swap      = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: begin
                if (frame_end_i) begin
                    w_swap      = 1'b1;
                    w_state_nxt = S_READY;
                end
            end
            S_READY: begin
                if (frame_end_i && frame_ready_i) begin
                    w_swap      = 1'b1;
                    w_state_nxt = S_READY;
                end else if (frame_end_i) begin
                    w_state_nxt = S_STALL;
                end else if (frame_ready_i) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_STALL: begin
                if (frame_ready_i) begin
                    w_swap      = 1'b1;
                    w_state_nxt = S_READY;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // Reads look ahead to the bank that is R after this edge; on a swap that is the
    // closing fill bank, which may also be taking a packet in this same cycle.
    assign w_rsel_nxt = w_swap ? r_fsel : ~r_fsel;
    assign w_base     = TOP_BASE - {rd_word_i, 5'b00000};

    always_comb begin
        w_row = '0;
        for (int c = 0; c < NUM_CORES; c++) begin
            if (rd_core_i == CORE_W'(c)) begin
                w_row = r_bank[w_rsel_nxt][c];
            end
        end
        if (w_swap && w_wr_en && (w_core == rd_core_i)) begin
            w_row[w_axon] = 1'b1;
        end
        w_rd_word = w_row[w_base +: 32];
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state       <= S_EMPTY;
            r_fsel        <= 1'b0;
            r_bank        <= '0;
            r_pkt_ready   <= 1'b1;
            r_frame_valid <= 1'b0;
            r_rd_data     <= '0;
            r_fill_cnt    <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pkt_ready   <= (w_state_nxt != S_STALL);
            r_frame_valid <= (w_state_nxt != S_EMPTY);
            r_rd_data     <= w_rd_word;

            if (w_wr_en) begin
                r_bank[r_fsel][w_core][w_axon] <= 1'b1;
            end
            // The bank being cleared is the old R, never the one the packet targets.
            if (w_swap) begin
                r_bank[~r_fsel] <= '0;
                r_fsel          <= ~r_fsel;
            end

            if (w_swap) begin
                r_fill_cnt <= '0;
            end else if (w_wr_en && (r_fill_cnt != {CNT_W{1'b1}})) begin
                r_fill_cnt <= r_fill_cnt + 1'b1;
            end

            if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

`ifdef SPIKE_FRAME_ROUTER_DUP_CNT_EN
    logic [CNT_W-1:0] r_dup_cnt;
    logic             w_dup_hit;

    assign w_dup_hit = w_wr_en & r_bank[r_fsel][w_core][w_axon];

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_dup_cnt <= '0;
        end else if (w_dup_hit && (r_dup_cnt != {CNT_W{1'b1}})) begin
            r_dup_cnt <= r_dup_cnt + 1'b1;
        end
    end

    assign dup_cnt_o = r_dup_cnt;
`else
    assign dup_cnt_o = '0;
`endif

    assign pkt_ready_o   = r_pkt_ready;
    assign frame_valid_o = r_frame_valid;
    assign rd_data_o     = r_rd_data;
    assign fill_cnt_o    = r_fill_cnt;
    assign drop_cnt_o    = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_spike_frame_router.sv
// tb_spike_frame_router: directed self-checking bench for spike_frame_router.
`default_nettype none

module tb_spike_frame_router;

    localparam int NUM_CORES = 5;
    localparam int NUM_AXONS = 256;
    localparam int CNT_W     = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pkt_valid = 1'b0;
    logic        pkt_ready;
    logic [31:0] pkt_data = '0;
    logic        frame_end = 1'b0;
    logic        frame_valid;
    logic        frame_ready = 1'b0;
    logic [2:0]  rd_core = '0;
    logic [2:0]  rd_word = '0;
    logic [31:0] rd_data;
    logic [CNT_W-1:0] fill_cnt;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] dup_cnt;

    int total = 0;
    int bad   = 0;

    spike_frame_router #(
        .NUM_CORES (NUM_CORES),
        .NUM_AXONS (NUM_AXONS),
        .CNT_W     (CNT_W)
    ) dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .pkt_valid_i   (pkt_valid),
        .pkt_ready_o   (pkt_ready),
        .pkt_data_i    (pkt_data),
        .frame_end_i   (frame_end),
        .frame_valid_o (frame_valid),
        .frame_ready_i (frame_ready),
        .rd_core_i     (rd_core),
        .rd_word_i     (rd_word),
        .rd_data_o     (rd_data),
        .fill_cnt_o    (fill_cnt),
        .drop_cnt_o    (drop_cnt),
        .dup_cnt_o     (dup_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Packet with nonzero dy and junk in the ignored fields.
    function automatic logic [31:0] mk_pkt(input int dx, input int ax);
        return {2'b11, 9'(dx), 9'h1A5, 8'(ax), 4'hF};
    endfunction

    task automatic send(input int dx, input int ax);
        pkt_data  = mk_pkt(dx, ax);
        pkt_valid = 1'b1;
        tick();
        pkt_valid = 1'b0;
    endtask

    task automatic rd(input int c, input int w, output logic [31:0] d);
        rd_core = 3'(c);
        rd_word = 3'(w);
        tick();
        d = rd_data;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pkt_valid = 1'b1;
        pkt_data  = mk_pkt(1, 1);
        tick(); tick();
        total++; if (pkt_ready !== 1'b1) begin bad++; $display("FAIL reset_pkt_ready got=%0b exp=1", pkt_ready); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_frame_valid got=%0b exp=0", frame_valid); end
        total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        total++; if (fill_cnt !== 16'd0) begin bad++; $display("FAIL reset_fill got=%0d exp=0", fill_cnt); end
        total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
        total++; if (dup_cnt !== 16'd0) begin bad++; $display("FAIL reset_dup got=%0d exp=0", dup_cnt); end
        pkt_valid = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] d;
        logic [31:0] e;
        send(0, 255);
        send(2, 0);
        total++; if (fill_cnt !== 16'd2) begin bad++; $display("FAIL basic_fill got=%0d exp=2", fill_cnt); end
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%0b exp=1", frame_valid); end
        total++; if (fill_cnt !== 16'd0) begin bad++; $display("FAIL basic_fill_zero got=%0d exp=0", fill_cnt); end
        for (int c = 0; c < NUM_CORES; c++) begin
            for (int w = 0; w < 8; w++) begin
                rd(c, w, d);
                e = 32'h0;
                if (c == 0 && w == 0) e = 32'h8000_0000;
                if (c == 2 && w == 7) e = 32'h0000_0001;
                total++; if (d !== e) begin bad++; $display("FAIL basic_read c=%0d w=%0d got=%h exp=%h", c, w, d, e); end
            end
        end
        rd(5, 0, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL basic_core_oob got=%h exp=0", d); end
    endtask

    task automatic test_drop();
        logic [31:0] d;
        send(5, 10);
        total++; if (drop_cnt !== 16'd1) begin bad++; $display("FAIL drop_cnt1 got=%0d exp=1", drop_cnt); end
        total++; if (fill_cnt !== 16'd0) begin bad++; $display("FAIL drop_fill got=%0d exp=0", fill_cnt); end
        send(511, 200);
        total++; if (drop_cnt !== 16'd2) begin bad++; $display("FAIL drop_cnt2 got=%0d exp=2", drop_cnt); end
        send(1, 3);
        total++; if (fill_cnt !== 16'd1) begin bad++; $display("FAIL drop_fill_in got=%0d exp=1", fill_cnt); end
        rd(0, 0, d);
        total++; if (d !== 32'h8000_0000) begin bad++; $display("FAIL drop_r_kept got=%h exp=80000000", d); end
    endtask

    task automatic test_stall();
        logic [31:0] d;
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        total++; if (pkt_ready !== 1'b0) begin bad++; $display("FAIL stall_ready got=%0b exp=0", pkt_ready); end
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%0b exp=1", frame_valid); end
        pkt_data  = mk_pkt(1, 9);
        pkt_valid = 1'b1;
        frame_end = 1'b1;
        tick();
        pkt_valid = 1'b0;
        frame_end = 1'b0;
        total++; if (pkt_ready !== 1'b0) begin bad++; $display("FAIL stall_end_ignored got=%0b exp=0", pkt_ready); end
        total++; if (fill_cnt !== 16'd1) begin bad++; $display("FAIL stall_fill_frozen got=%0d exp=1", fill_cnt); end
        rd(0, 0, d);
        total++; if (d !== 32'h8000_0000) begin bad++; $display("FAIL stall_r_frame_a got=%h exp=80000000", d); end
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        total++; if (pkt_ready !== 1'b1) begin bad++; $display("FAIL stall_release_ready got=%0b exp=1", pkt_ready); end
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL stall_release_valid got=%0b exp=1", frame_valid); end
        total++; if (fill_cnt !== 16'd0) begin bad++; $display("FAIL stall_release_fill got=%0d exp=0", fill_cnt); end
        rd(1, 7, d);
        total++; if (d !== 32'h0000_0008) begin bad++; $display("FAIL stall_frame_b got=%h exp=00000008", d); end
        rd(0, 0, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL stall_frame_a_gone got=%h exp=0", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        send(4, 100);
        pkt_data    = mk_pkt(3, 31);
        pkt_valid   = 1'b1;
        frame_end   = 1'b1;
        frame_ready = 1'b1;
        rd_core     = 3'd3;
        rd_word     = 3'd7;
        tick();
        pkt_valid   = 1'b0;
        frame_end   = 1'b0;
        frame_ready = 1'b0;
        total++; if (rd_data !== 32'h8000_0000) begin bad++; $display("FAIL b2b_swap_read got=%h exp=80000000", rd_data); end
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%0b exp=1", frame_valid); end
        total++; if (pkt_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%0b exp=1", pkt_ready); end
        total++; if (fill_cnt !== 16'd0) begin bad++; $display("FAIL b2b_fill got=%0d exp=0", fill_cnt); end
        rd(4, 4, d);
        total++; if (d !== 32'h0000_0010) begin bad++; $display("FAIL b2b_core4 got=%h exp=00000010", d); end
        rd(1, 7, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL b2b_old_gone got=%h exp=0", d); end
    endtask

    task automatic test_dup();
        logic [31:0] d;
        logic [CNT_W-1:0] e_dup;
`ifdef SPIKE_FRAME_ROUTER_DUP_CNT_EN
        e_dup = 16'd2;
`else
        e_dup = 16'd0;
`endif
        send(1, 17);
        send(1, 17);
        send(1, 17);
        total++; if (fill_cnt !== 16'd3) begin bad++; $display("FAIL dup_fill got=%0d exp=3", fill_cnt); end
        total++; if (dup_cnt !== e_dup) begin bad++; $display("FAIL dup_cnt got=%0d exp=%0d", dup_cnt, e_dup); end
        frame_end   = 1'b1;
        frame_ready = 1'b1;
        tick();
        frame_end   = 1'b0;
        frame_ready = 1'b0;
        rd(1, 7, d);
        total++; if (d !== 32'h0002_0000) begin bad++; $display("FAIL dup_bit17 got=%h exp=00020000", d); end
        rd(4, 4, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL dup_prev_gone got=%h exp=0", d); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        logic [31:0] e;
        send(0, 5);
        pkt_data  = mk_pkt(2, 200);
        pkt_valid = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        total++; if (pkt_ready !== 1'b1) begin bad++; $display("FAIL arst_ready got=%0b exp=1", pkt_ready); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%0b exp=0", frame_valid); end
        total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL arst_rd_data got=%h exp=0", rd_data); end
        total++; if (fill_cnt !== 16'd0) begin bad++; $display("FAIL arst_fill got=%0d exp=0", fill_cnt); end
        total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL arst_drop got=%0d exp=0", drop_cnt); end
        total++; if (dup_cnt !== 16'd0) begin bad++; $display("FAIL arst_dup got=%0d exp=0", dup_cnt); end
        tick(); tick();
        pkt_valid = 1'b0;
        rst = 1'b0;
        tick();
        send(3, 64);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL arst_new_valid got=%0b exp=1", frame_valid); end
        for (int c = 0; c < NUM_CORES; c++) begin
            for (int w = 0; w < 8; w++) begin
                rd(c, w, d);
                e = (c == 3 && w == 5) ? 32'h0000_0001 : 32'h0;
                total++; if (d !== e) begin bad++; $display("FAIL arst_read c=%0d w=%0d got=%h exp=%h", c, w, d, e); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drop();
        test_stall();
        test_back_to_back();
        test_dup();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
